awb_gain: RTL

- Gray-world auto white balance stage. Sits directly upstream of the gamma LUT stage.
- Feeds that stage's in_R/in_G/in_B with white-balanced 8-bit RGB.
- Accumulates per-channel sums over each frame and computes R and B gains with a serial divider during blanking.
- Applies the gains to the following frame through a 3-stage multiply/round/saturate pipeline.

---
 rtl/awb_gain.sv | 297 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/awb_gain.sv
// awb_gain: gray-world auto white balance; per-frame RGB sums feed a serial divider that yields R/B gains for the next frame.
// Latency: pixel path exactly 3 cycles; new gains ready 23 cycles after frame end, applied at the following frame start.
// Backpressure: none; one pixel per cycle in and out, the pipeline never stalls.

module awb_gain #(
  parameter int SUM_W    = 30,
  parameter int GAIN_MIN = 64,
  parameter int GAIN_MAX = 1023
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       awb_en,
  input  logic       in_vs,
  input  logic       in_de,
  input  logic [7:0] in_R,
  input  logic [7:0] in_G,
  input  logic [7:0] in_B,
  output logic       out_vs,
  output logic       out_de,
  output logic [7:0] out_R,
  output logic [7:0] out_G,
  output logic [7:0] out_B,
  output logic [9:0] gain_r,
  output logic [9:0] gain_b,
  output logic       awb_busy
);

  localparam int          NUM_W    = SUM_W + 8;
  localparam int          DIV_W    = SUM_W + 11;
  localparam logic [9:0]  GAIN_ONE = 10'd256;
  localparam logic [10:0] GMIN_Q   = 11'(GAIN_MIN);
  localparam logic [10:0] GMAX_Q   = 11'(GAIN_MAX);

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  typedef enum logic [1:0] {IDLE, DIV_R, DIV_B, UPDATE} state_t;

  // frame edge tracking
  logic vs_prev_q, vs_prev_d;
  logic frame_q, frame_d;
  logic vs_rise, vs_fall;

  // statistics
  logic [SUM_W-1:0] sum_r_q, sum_r_d, sum_g_q, sum_g_d, sum_b_q, sum_b_d;

  // applied and shadow gains
  logic [9:0] gain_r_q, gain_r_d, gain_b_q, gain_b_d;
  logic [9:0] shadow_r_q, shadow_r_d, shadow_b_q, shadow_b_d;

  // divider
  state_t           state_q, state_d;
  logic [NUM_W-1:0] num_q, num_d;
  logic [SUM_W-1:0] den_r_q, den_r_d, den_b_q, den_b_d;
  logic [DIV_W-1:0] rem_q, rem_d, dsh_q, dsh_d;
  logic [9:0]       quo_q, quo_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [9:0]       res_r_q, res_r_d, res_b_q, res_b_d;
  logic [SUM_W-1:0] cur_den;
  logic [DIV_W-1:0] den_sh;
  logic             div_zero, div_ovf, step_ge;
  logic [10:0]      quo_nx;
  logic [9:0]       div_res;

  // pixel pipeline
  logic        s1_vs_q, s1_vs_d, s1_de_q, s1_de_d;
  rgb_t        s1_pix_q, s1_pix_d;
  logic        s2_vs_q, s2_vs_d, s2_de_q, s2_de_d;
  logic [17:0] s2_pr_q, s2_pr_d, s2_pb_q, s2_pb_d;
  logic [7:0]  s2_g_q, s2_g_d;
  logic        s3_vs_q, s3_vs_d, s3_de_q, s3_de_d;
  rgb_t        s3_pix_q, s3_pix_d;

  function automatic logic [9:0] clamp_gain(input logic [10:0] q);
    if (q < GMIN_Q) begin
      return GMIN_Q[9:0];
    end else if (q > GMAX_Q) begin
      return GMAX_Q[9:0];
    end
    return q[9:0];
  endfunction

  function automatic logic [7:0] round_sat(input logic [17:0] p);
    logic [10:0] sh;
    sh = 11'((19'(p) + 19'd128) >> 8);
    if (sh > 11'd255) begin
      return 8'hFF;
    end
    return sh[7:0];
  endfunction

  // Frame start/end detection; a frame only counts if its start was seen after reset
  always_comb begin
    vs_prev_d = in_vs;
    frame_d   = frame_q;
    vs_rise   = in_vs & ~vs_prev_q;
    vs_fall   = ~in_vs & vs_prev_q & frame_q;
    if (vs_rise) begin
      frame_d = 1'b1;
    end else if (!in_vs) begin
      frame_d = 1'b0;
    end
  end

  // Per-channel sums; the pixel on the frame-start cycle starts the new sum
  always_comb begin
    sum_r_d = sum_r_q;
    sum_g_d = sum_g_q;
    sum_b_d = sum_b_q;
    if (vs_rise) begin
      sum_r_d = in_de ? SUM_W'(in_R) : '0;
      sum_g_d = in_de ? SUM_W'(in_G) : '0;
      sum_b_d = in_de ? SUM_W'(in_B) : '0;
    end else if (in_vs && in_de && frame_q) begin
      sum_r_d = sum_r_q + SUM_W'(in_R);
      sum_g_d = sum_g_q + SUM_W'(in_G);
      sum_b_d = sum_b_q + SUM_W'(in_B);
    end
  end

  // Applied gains change only at frame start, so a frame never sees a mid-frame step
  always_comb begin
    gain_r_d = gain_r_q;
    gain_b_d = gain_b_q;
    if (vs_rise) begin
      gain_r_d = awb_en ? shadow_r_q : GAIN_ONE;
      gain_b_d = awb_en ? shadow_b_q : GAIN_ONE;
    end
  end

  // Divider FSM: two fixed-length 11-step restoring divisions then one shadow-update cycle
  always_comb begin
    state_d    = state_q;
    num_d      = num_q;
    den_r_d    = den_r_q;
    den_b_d    = den_b_q;
    rem_d      = rem_q;
    dsh_d      = dsh_q;
    quo_d      = quo_q;
    cnt_d      = cnt_q;
    res_r_d    = res_r_q;
    res_b_d    = res_b_q;
    shadow_r_d = shadow_r_q;
    shadow_b_d = shadow_b_q;

    cur_den  = (state_q == DIV_B) ? den_b_q : den_r_q;
    den_sh   = DIV_W'(cur_den) << 10;
    div_zero = (cur_den == '0);
    div_ovf  = (DIV_W'(num_q) >= den_sh);
    step_ge  = (rem_q >= dsh_q);
    quo_nx   = {quo_q, step_ge};
    if (div_zero) begin
      div_res = GAIN_ONE;
    end else if (div_ovf) begin
      div_res = GMAX_Q[9:0];
    end else begin
      div_res = clamp_gain(quo_nx);
    end

    unique case (state_q)
      IDLE: begin
        if (vs_fall) begin
          num_d   = {sum_g_q, 8'h00};
          den_r_d = sum_r_q;
          den_b_d = sum_b_q;
          rem_d   = DIV_W'({sum_g_q, 8'h00});
          dsh_d   = DIV_W'(sum_r_q) << 10;
          quo_d   = '0;
          cnt_d   = '0;
          state_d = DIV_R;
        end
      end
      DIV_R, DIV_B: begin
        if (step_ge) begin
          rem_d = rem_q - dsh_q;
        end
        dsh_d = dsh_q >> 1;
        quo_d = quo_nx[9:0];
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd10) begin
          cnt_d = '0;
          quo_d = '0;
          if (state_q == DIV_R) begin
            res_r_d = div_res;
            rem_d   = DIV_W'(num_q);
            dsh_d   = DIV_W'(den_b_q) << 10;
            state_d = DIV_B;
          end else begin
            res_b_d = div_res;
            state_d = UPDATE;
          end
        end
      end
      UPDATE: begin
        shadow_r_d = res_r_q;
        shadow_b_d = res_b_q;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Pixel path: register, multiply, round and saturate
  always_comb begin
    s1_vs_d  = in_vs;
    s1_de_d  = in_de;
    s1_pix_d = {in_R, in_G, in_B};
    s2_vs_d  = s1_vs_q;
    s2_de_d  = s1_de_q;
    s2_pr_d  = 18'(s1_pix_q.r) * 18'(gain_r_q);
    s2_pb_d  = 18'(s1_pix_q.b) * 18'(gain_b_q);
    s2_g_d   = s1_pix_q.g;
    s3_vs_d  = s2_vs_q;
    s3_de_d  = s2_de_q;
    s3_pix_d = {round_sat(s2_pr_q), s2_g_q, round_sat(s2_pb_q)};
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      vs_prev_q  <= 1'b1;
      frame_q    <= 1'b0;
      sum_r_q    <= '0;
      sum_g_q    <= '0;
      sum_b_q    <= '0;
      gain_r_q   <= GAIN_ONE;
      gain_b_q   <= GAIN_ONE;
      shadow_r_q <= GAIN_ONE;
      shadow_b_q <= GAIN_ONE;
      state_q    <= IDLE;
      num_q      <= '0;
      den_r_q    <= '0;
      den_b_q    <= '0;
      rem_q      <= '0;
      dsh_q      <= '0;
      quo_q      <= '0;
      cnt_q      <= '0;
      res_r_q    <= GAIN_ONE;
      res_b_q    <= GAIN_ONE;
      s1_vs_q    <= 1'b0;
      s1_de_q    <= 1'b0;
      s1_pix_q   <= '0;
      s2_vs_q    <= 1'b0;
      s2_de_q    <= 1'b0;
      s2_pr_q    <= '0;
      s2_pb_q    <= '0;
      s2_g_q     <= '0;
      s3_vs_q    <= 1'b0;
      s3_de_q    <= 1'b0;
      s3_pix_q   <= '0;
    end else begin
      vs_prev_q  <= vs_prev_d;
      frame_q    <= frame_d;
      sum_r_q    <= sum_r_d;
      sum_g_q    <= sum_g_d;
      sum_b_q    <= sum_b_d;
      gain_r_q   <= gain_r_d;
      gain_b_q   <= gain_b_d;
      shadow_r_q <= shadow_r_d;
      shadow_b_q <= shadow_b_d;
      state_q    <= state_d;
      num_q      <= num_d;
      den_r_q    <= den_r_d;
      den_b_q    <= den_b_d;
      rem_q      <= rem_d;
      dsh_q      <= dsh_d;
      quo_q      <= quo_d;
      cnt_q      <= cnt_d;
      res_r_q    <= res_r_d;
      res_b_q    <= res_b_d;
      s1_vs_q    <= s1_vs_d;
      s1_de_q    <= s1_de_d;
      s1_pix_q   <= s1_pix_d;
      s2_vs_q    <= s2_vs_d;
      s2_de_q    <= s2_de_d;
      s2_pr_q    <= s2_pr_d;
      s2_pb_q    <= s2_pb_d;
      s2_g_q     <= s2_g_d;
      s3_vs_q    <= s3_vs_d;
      s3_de_q    <= s3_de_d;
      s3_pix_q   <= s3_pix_d;
    end
  end

  assign out_vs   = s3_vs_q;
  assign out_de   = s3_de_q;
  assign out_R    = s3_pix_q.r;
  assign out_G    = s3_pix_q.g;
  assign out_B    = s3_pix_q.b;
  assign gain_r   = gain_r_q;
  assign gain_b   = gain_b_q;
  assign awb_busy = (state_q != IDLE);

endmodule
